mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit in the EX stage, next to the register file.
//   Consumes the two register-file read operands (rs, rt) and executes MULT/MULTU/DIV/DIVU
//   into private HI/LO registers. Also executes MTHI/MTLO.
//   HI/LO are returned to the register file via MFHI/MFLO through the normal writeback path.
//   busy stalls ID/EX; flush aborts work when interrupt||exception is taken.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO width; iteration count = WIDTH
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   start      in   1      issue op; sampled only when busy==0
//   op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   mthi       in   1      HI <= operand_a (idle only)
//   mtlo       in   1      LO <= operand_a (idle only)
//   flush      in   1      interrupt||exception: abort in-flight op
//   operand_a  in   WIDTH  rs value (dividend / multiplicand / mthi-mtlo data)
//   operand_b  in   WIDTH  rt value (divisor / multiplier)
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse after HI/LO updated by an op
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
// BEHAVIOUR
//   Reset (sync): state=IDLE, hi=lo=0, busy=0, done=0, counter=0.
//   Reset wins over every other input, including mid-operation.
//   FSM: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE, start=1 at edge E0: latch |a|, |b| for signed ops, raw values for unsigned ops.
//     Also latch result sign, remainder sign, op, and div0=(op[1] && b==0). counter=0, go CALC.
//   - CALC: one radix-2 step per edge. Multiply = shift-add into 2*WIDTH accumulator.
//     Divide = restoring shift-subtract. counter++.
//     At E(WIDTH) (counter==WIDTH-1 before edge): go FIX.
//   - FIX, edge E(WIDTH+1): sign-correct the product, quotient, and remainder. Write hi/lo.
//     done=1 for the following cycle, go IDLE.
//   Latency: start at E0 -> hi/lo/done valid after E33 (WIDTH=32); busy high for 33 cycles.
//   Results:
//   - MULT/MULTU: {hi,lo} = full 64-bit product; signed negated when sign(a)!=sign(b).
//   - DIV/DIVU: lo = quotient, hi = remainder.
//     Signed: quotient negative iff signs differ; remainder takes the sign of the dividend.
//     -2^31 / -1 -> lo=0x80000000, hi=0 (wraps, no trap).
//   - Divide by zero (signed or unsigned): full latency, hi=operand_a as latched, lo=0xFFFFFFFF.
//   Priority each edge: reset > flush > start (IDLE) > mthi/mtlo (IDLE).
//   - start while busy: ignored (ID hazard logic stalls on busy).
//   - mthi/mtlo while busy, or same cycle as an accepted start: ignored.
//   - mthi and mtlo together: both written.
//   - flush in CALC/FIX: go IDLE next edge. hi/lo keep pre-op values; no done pulse.
//   - flush and start in the same IDLE cycle: start dropped.
//   - done cycle is IDLE; a new start is accepted in that same cycle.
//   Only flip-flops drive the outputs; hi/lo never change except at FIX, mthi/mtlo, or reset.
// STRUCTURE
//   Shared header mdu_defs.vh: op encodings (MDU_MULT/MULTU/DIV/DIVU), state encodings
//   (S_IDLE/S_CALC/S_FIX), WIDTH default.
//   One sub-module mdu_iter_step: combinational single step.
//   - Multiply: add-or-pass plus shift.
//   - Divide: trial subtract, select, shift.
//   Top holds the FSM, counter, operand/accumulator registers, sign fix, and HI/LO.
// TESTING
//   1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 busy cycles hi=0xFFFFFFFE lo=0x00000001, done 1 cycle.
//   2 MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
//   3 DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU a=7 b=2 -> lo=3, hi=1.
//   4 DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234.
//     DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//   5 MTHI 0xAAAA, MTLO 0x5555, then MULT 2*3.
//     Assert flush at cycle 10 -> busy drops next edge, hi=0xAAAA lo=0x5555, no done.
//   6 During DIV: assert start (different operands) and mthi -> ignored, original result unchanged.
//     Reset at cycle 5 -> next edge hi=lo=0, busy=0.
//     start on the done cycle -> accepted.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH     default operand / HI / LO width
//   mdu_op_e      operation encodings driven on the op port
//   mdu_state_e   sequencer states of the top-level FSM
package mul_div_unit_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// Combinational single radix-2 step shared by multiply and divide.
//   is_div   in   1        select restoring-divide step (1) or shift-add multiply step (0)
//   acc_in   in   2*WIDTH  accumulator: multiply {partial_hi, multiplier}, divide {remainder, dividend/quotient}
//   operand  in   WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_out  out  2*WIDTH  accumulator after one step
module mdu_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] diff;

   // Multiply adds the multiplicand into the upper half when the current
   // multiplier LSB is set, then shifts right keeping the carry. Divide
   // shifts the next dividend bit into the remainder and keeps the trial
   // subtraction only when it does not borrow (diff MSB clear).
   always_comb begin
      sum       = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      rem_shift = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      diff      = rem_shift - {1'b0, operand};
      acc_out   = {sum, acc_in[WIDTH-1:1]};
      if (is_div) begin
         if (!diff[WIDTH]) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {rem_shift[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   start      in   issue op (accepted only while idle)
//   op         in   MULT / MULTU / DIV / DIVU
//   mthi/mtlo  in   write operand_a into HI / LO while idle
//   flush      in   abort in-flight op, HI/LO untouched
//   operand_a  in   rs: multiplicand / dividend / move data
//   operand_b  in   rt: multiplier / divisor
//   busy       out  unit is not idle
//   done       out  one-cycle pulse after HI/LO written by an op
//   hi, lo     out  HI and LO registers
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_e           state_q, state_d;
   mdu_op_e              op_q, op_d;
   logic [CW-1:0]        counter_q, counter_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     a_raw_q, a_raw_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic                 div0_q, div0_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;

   logic                 is_signed;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [2*WIDTH-1:0]   acc_step;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     quotient, remainder;

   mdu_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (op_q[1]),
      .acc_in  (acc_q),
      .operand (opnd_q),
      .acc_out (acc_step)
   );

   // Operand magnitudes for issue, and sign-corrected results from the
   // finished accumulator. op[0] clear means a signed operation.
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & operand_a[WIDTH-1];
      b_neg     = is_signed & operand_b[WIDTH-1];
      a_abs     = a_neg ? -operand_a : operand_a;
      b_abs     = b_neg ? -operand_b : operand_b;
      product   = neg_res_q ? -acc_q : acc_q;
      quotient  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      remainder = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state logic: flush beats start, start beats moves, and moves are
   // only honoured when idle and not starting. Divide by zero runs the full
   // iteration and then overrides the result with the raw dividend.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      counter_d = counter_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      a_raw_d   = a_raw_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (start) begin
               op_d      = mdu_op_e'(op);
               counter_d = '0;
               a_raw_d   = operand_a;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               div0_d    = op[1] && (operand_b == '0);
               if (op[1]) begin
                  acc_d  = {{WIDTH{1'b0}}, a_abs};
                  opnd_d = b_abs;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, b_abs};
                  opnd_d = a_abs;
               end
               state_d = S_CALC;
            end else begin
               if (mthi) hi_d = operand_a;
               if (mtlo) lo_d = operand_a;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d     = acc_step;
               counter_d = counter_q + 1'b1;
               if (counter_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!op_q[1]) begin
                  hi_d = product[2*WIDTH-1:WIDTH];
                  lo_d = product[WIDTH-1:0];
               end else if (div0_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = remainder;
                  lo_d = quotient;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State register; reset overrides everything, including an op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= MDU_MULT;
         counter_q <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         a_raw_q   <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         counter_q <= counter_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         a_raw_q   <= a_raw_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: arithmetic results, latency,
// divide-by-zero and overflow corners, moves, flush, reset and back-to-back issue.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .flush     (flush),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Drive start for exactly one rising edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for the done pulse, counting busy cycles seen before it.
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cycles++;
      end
   endtask

   task automatic move(input logic h, input logic l, input logic [31:0] d);
      mthi = h; mtlo = l; operand_a = d;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
   endtask

   task automatic test_mult();
      int cyc; bit seen;
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(cyc, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL multu_done_seen got %b want 1", seen); end
      checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL multu_busy_cycles got %0d want 33", cyc); end
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi got %h want fffffffe", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo got %h want 00000001", lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle got %b want 0", done); end

      issue(2'b00, 32'hFFFFFFFD, 32'd7);
      wait_done(cyc, seen);
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_neg_hi got %h want ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_neg_lo got %h want ffffffeb", lo); end

      issue(2'b01, 32'h00010000, 32'h00010000);
      wait_done(cyc, seen);
      checks++; if (hi !== 32'h1) begin errors++; $display("[TB] FAIL multu_carry_hi got %h want 1", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL multu_carry_lo got %h want 0", lo); end
   endtask

   task automatic test_div();
      int cyc; bit seen;
      issue(2'b10, 32'hFFFFFFF9, 32'd2);
      wait_done(cyc, seen);
      checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL div_busy_cycles got %0d want 33", cyc); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi got %h want ffffffff", hi); end

      issue(2'b11, 32'd7, 32'd2);
      wait_done(cyc, seen);
      checks++; if (lo !== 32'd3) begin errors++; $display("[TB] FAIL divu_lo got %h want 3", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL divu_hi got %h want 1", hi); end

      issue(2'b10, 32'd7, 32'hFFFFFFFE);
      wait_done(cyc, seen);
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_negb_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL div_negb_hi got %h want 1", hi); end
   endtask

   task automatic test_div_boundary();
      int cyc; bit seen;
      issue(2'b11, 32'h1234, 32'h0);
      wait_done(cyc, seen);
      checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL div0_busy_cycles got %0d want 33", cyc); end
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu0_lo got %h want ffffffff", lo); end
      checks++; if (hi !== 32'h1234) begin errors++; $display("[TB] FAIL divu0_hi got %h want 1234", hi); end

      issue(2'b10, 32'hFFFFFFFB, 32'h0);
      wait_done(cyc, seen);
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div0_lo got %h want ffffffff", lo); end
      checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("[TB] FAIL div0_hi got %h want fffffffb", hi); end

      issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_done(cyc, seen);
      checks++; if (lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi got %h want 0", hi); end
   endtask

   task automatic test_flush();
      int dones;
      move(1'b1, 1'b1, 32'h77);
      @(negedge clk);
      checks++; if (hi !== 32'h77) begin errors++; $display("[TB] FAIL move_both_hi got %h want 77", hi); end
      checks++; if (lo !== 32'h77) begin errors++; $display("[TB] FAIL move_both_lo got %h want 77", lo); end
      move(1'b1, 1'b0, 32'hAAAA);
      move(1'b0, 1'b1, 32'h5555);
      @(negedge clk);
      checks++; if (hi !== 32'hAAAA) begin errors++; $display("[TB] FAIL mthi got %h want aaaa", hi); end
      checks++; if (lo !== 32'h5555) begin errors++; $display("[TB] FAIL mtlo got %h want 5555", lo); end

      issue(2'b00, 32'd2, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("[TB] FAIL flush_no_done got %0d pulses want 0", dones); end
      checks++; if (hi !== 32'hAAAA) begin errors++; $display("[TB] FAIL flush_hi got %h want aaaa", hi); end
      checks++; if (lo !== 32'h5555) begin errors++; $display("[TB] FAIL flush_lo got %h want 5555", lo); end

      flush = 1'b1;
      issue(2'b01, 32'd4, 32'd4);
      flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_drops_start got busy %b want 0", busy); end
   endtask

   task automatic test_busy_ignore();
      int cyc; bit seen;
      issue(2'b10, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b01; operand_a = 32'd5; operand_b = 32'd5; mthi = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      wait_done(cyc, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done_seen got %b want 1", seen); end
      checks++; if (lo !== 32'd14) begin errors++; $display("[TB] FAIL ignore_lo got %h want e", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("[TB] FAIL ignore_hi got %h want 2", hi); end
   endtask

   task automatic test_reset_mid();
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL midreset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_lo got %h want 0", lo); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done); end
   endtask

   task automatic test_back_to_back();
      int cyc; bit seen;
      issue(2'b11, 32'd7, 32'd2);
      wait_done(cyc, seen);
      checks++; if (lo !== 32'd3) begin errors++; $display("[TB] FAIL b2b_first_lo got %h want 3", lo); end
      checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL b2b_first_hi got %h want 1", hi); end
      issue(2'b00, 32'hFFFFFFFD, 32'd7);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accepted got busy %b want 1", busy); end
      wait_done(cyc, seen);
      checks++; if (cyc != 32) begin errors++; $display("[TB] FAIL b2b_busy_cycles got %0d want 32", cyc); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL b2b_second_hi got %h want ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL b2b_second_lo got %h want ffffffeb", lo); end
   endtask

   // Scenario sequence; each task leaves the unit idle for the next one.
   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_boundary();
      test_flush();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
